// File: rtl/rc5_l_loader.sv
// -----------------------------------------------------------------------------
// rc5_l_loader
// Builds the RC5 L array from a secret key of runtime length b bytes.
// Key bytes are fetched one at a time from a synchronous key RAM with a
// 1-cycle read latency. They are packed little-endian into c = max(1, ceil(b/U))
// words of W bits. Missing tail bytes are zero-filled, and each word is written
// once to the L RAM. The word count c is reported for the S/L mixing stage.
//
// State table
//   state   | meaning
//   IDLE    | waiting for start; key length and word count latched on start
//   ADDR    | drive key RAM address for byte i (address 0 beyond the key)
//   DATA    | key RAM data valid; merge byte i into accumulator lane i%U
//   WRITE   | one-cycle L RAM write of accumulator to L[j]; clear accumulator
//   DONE    | one-cycle done pulse; c_len now holds c
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous reset, active-high
//   start          begin a load (only looked at in IDLE)
//   key_len        key length b in bytes, saturated to B_MAX
//   key_address    key RAM read address
//   key_sub_i      key RAM read data, valid one cycle after key_address
//   L_address      L RAM write address
//   L_sub_i_prima  L RAM write data
//   L_we           L RAM write enable, single-cycle pulses
//   c_len          number of L words c, valid from done until the next start
//   busy           high in every state except IDLE
//   done           single-cycle completion pulse
// -----------------------------------------------------------------------------
module rc5_l_loader #(
  parameter int W     = 32,
  parameter int B_MAX = 16,
  localparam int U     = W / 8,
  localparam int C_MAX = (B_MAX + U - 1) / U,
  localparam int KA_W  = (B_MAX > 1) ? $clog2(B_MAX) : 1,
  localparam int LA_W  = (C_MAX > 1) ? $clog2(C_MAX) : 1,
  localparam int KL_W  = $clog2(B_MAX + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [KL_W-1:0] key_len,
  output logic [KA_W-1:0] key_address,
  input  logic [7:0]      key_sub_i,
  output logic [LA_W-1:0] L_address,
  output logic [W-1:0]    L_sub_i_prima,
  output logic            L_we,
  output logic [LA_W:0]   c_len,
  output logic            busy,
  output logic            done
);

  // The byte index runs over the whole padded range U*c, which can exceed
  // B_MAX when b is not a multiple of U.
  localparam int I_W   = $clog2(C_MAX * U + 1);
  localparam int SEL_W = $clog2(U);
  localparam int CL_W  = LA_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [I_W-1:0]  i, i_n;
  logic [LA_W-1:0] j, j_n;
  logic [W-1:0]    acc, acc_n;
  logic [KL_W-1:0] b, b_n;
  logic [CL_W-1:0] c, c_n;
  logic [CL_W-1:0] c_len_q, c_len_n;

  logic [KL_W-1:0]  b_sat;
  logic [CL_W-1:0]  c_calc;
  logic             in_key;
  logic [SEL_W-1:0] byte_sel;
  logic             last_word;

  assign b_sat    = (key_len > KL_W'(B_MAX)) ? KL_W'(B_MAX) : key_len;
  // An empty key still produces one all-zero word.
  assign c_calc   = (b_sat == '0) ? CL_W'(1)
                                  : CL_W'((int'(b_sat) + U - 1) / U);
  assign in_key   = (int'(i) < int'(b));
  assign byte_sel = i[SEL_W-1:0];
  assign last_word = (CL_W'(j) == (c - CL_W'(1)));
  assign c_len    = c_len_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      i       <= '0;
      j       <= '0;
      acc     <= '0;
      b       <= '0;
      c       <= '0;
      c_len_q <= '0;
    end else begin
      state   <= state_n;
      i       <= i_n;
      j       <= j_n;
      acc     <= acc_n;
      b       <= b_n;
      c       <= c_n;
      c_len_q <= c_len_n;
    end
  end

  always_comb begin
    state_n       = state;
    i_n           = i;
    j_n           = j;
    acc_n         = acc;
    b_n           = b;
    c_n           = c;
    c_len_n       = c_len_q;
    key_address   = '0;
    L_address     = '0;
    L_sub_i_prima = '0;
    L_we          = 1'b0;
    busy          = (state != S_IDLE);
    done          = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          b_n     = b_sat;
          c_n     = c_calc;
          i_n     = '0;
          j_n     = '0;
          acc_n   = '0;
          state_n = S_ADDR;
        end
      end

      S_ADDR: begin
        // Padding bytes park the RAM address at 0; their data is discarded.
        if (in_key) key_address = i[KA_W-1:0];
        state_n = S_DATA;
      end

      S_DATA: begin
        acc_n[8*int'(byte_sel) +: 8] = in_key ? key_sub_i : 8'h00;
        if (byte_sel == SEL_W'(U - 1)) begin
          state_n = S_WRITE;
        end else begin
          i_n     = i + I_W'(1);
          state_n = S_ADDR;
        end
      end

      S_WRITE: begin
        L_we          = 1'b1;
        L_address     = j;
        L_sub_i_prima = acc;
        acc_n         = '0;
        if (last_word) begin
          c_len_n = c;
          state_n = S_DONE;
        end else begin
          j_n     = j + LA_W'(1);
          i_n     = i + I_W'(1);
          state_n = S_ADDR;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule
